// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array slice: default geometry and the
// result-drain state encoding.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int DEF_ROWS  = 8;
    localparam int DEF_COLS  = 8;
    localparam int DEF_ACC_W = 12;
    localparam int DEF_OUT_W = 8;
    localparam int N         = DEF_ROWS * DEF_COLS;

    // Index width for n elements; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_drain_acc_narrow.sv
// Unsigned narrowing of one accumulator to an output byte, either by dropping
// the high bits or by clamping to the largest representable value.
module acc_narrow #(
    parameter int ACC_W = 12,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic             i_sat,
    output logic [OUT_W-1:0] o_byte
);

    logic w_over;

    generate
        if (ACC_W > OUT_W) begin : g_wide
            assign w_over = |i_acc[ACC_W-1:OUT_W];
        end else begin : g_same
            assign w_over = 1'b0;
        end
    endgenerate

    // Select clamped or truncated value.
    always_comb begin
        o_byte = i_acc[OUT_W-1:0];
        if (i_sat && w_over) begin
            o_byte = {OUT_W{1'b1}};
        end else begin
            o_byte = i_acc[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots every accumulator of the array on start and streams the narrowed
// results out row-major over a byte-wide valid/ready channel.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        sat_mode,
    input  logic [ROWS*COLS*ACC_W-1:0]  acc_flat,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int NC = ROWS * COLS;
    localparam int IW = idx_w(NC);
    localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [IW-1:0]              r_idx;
    logic [IW-1:0]              w_next_elem;
    logic [ROWS*COLS*ACC_W-1:0] r_snap;
    logic                       r_sat;
    logic [OUT_W-1:0]           r_data;
    logic                       r_valid;
    logic                       r_last;
    logic                       r_busy;
    logic                       r_done;
    logic                       w_hs;
    logic                       w_load;
    logic                       w_advance;
    logic                       w_finish;
    logic [ACC_W-1:0]           w_sel_acc;
    logic                       w_sel_sat;
    logic [OUT_W-1:0]           w_narrow;

    assign w_hs      = r_valid & out_ready;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only seen in IDLE so it cannot queue.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = STREAM;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STREAM: begin
                if (w_hs && (r_idx == LAST_IDX)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_hs) begin
                    w_advance   = 1'b1;
                    w_state_nxt = STREAM;
                end else begin
                    w_state_nxt = STREAM;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Element to present next: cell 0 straight from the array on start,
    // otherwise the following snapshot entry.
    always_comb begin
        w_next_elem = (r_idx == LAST_IDX) ? {IW{1'b0}} : (r_idx + IW'(1));
        if (r_state == IDLE) begin
            w_sel_acc = acc_flat[0 +: ACC_W];
            w_sel_sat = sat_mode;
        end else begin
            w_sel_acc = r_snap[w_next_elem * ACC_W +: ACC_W];
            w_sel_sat = r_sat;
        end
    end

    acc_narrow #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_narrow (
        .i_acc  (w_sel_acc),
        .i_sat  (w_sel_sat),
        .o_byte (w_narrow)
    );

    // Snapshot is data-only and intentionally not cleared.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_snap <= acc_flat;
        end else begin
            r_snap <= r_snap;
        end
    end

    // Output channel, index and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= {IW{1'b0}};
            r_data  <= {OUT_W{1'b0}};
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == STREAM);
            r_done <= w_finish;
            if (w_load) begin
                r_idx   <= {IW{1'b0}};
                r_data  <= w_narrow;
                r_valid <= 1'b1;
                r_last  <= (LAST_IDX == {IW{1'b0}});
                r_sat   <= sat_mode;
            end else if (w_advance) begin
                r_idx  <= w_next_elem;
                r_data <= w_narrow;
                r_last <= (w_next_elem == LAST_IDX);
            end else if (w_finish) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx   <= r_idx;
                r_data  <= r_data;
                r_valid <= r_valid;
                r_last  <= r_last;
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized scoreboard bench for systolic_result_drain: stimulus queues the
// expected bytes, an independent monitor checks every handshake and stall.
module tb_systolic_result_drain;

    localparam int NE = 64;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              sat_mode;
    logic              out_ready;
    logic [NE*AW-1:0]  acc_flat;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         cells[NE];
    int         pop_count = 0;
    int         ready_mode = 0;
    bit         exp_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [5:0] pat = 6'b101001;

    systolic_result_drain dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sat_mode  (sat_mode),
        .acc_flat  (acc_flat),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] narrow_ref(input int acc, input bit s);
        if (s && acc > 255) return 8'd255;
        return 8'(acc % 256);
    endfunction

    // Sink ready: always, fixed 1,0,0,1,0,1 pattern, or random.
    initial begin
        int pi;
        pi = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[pi];
                    pi = (pi + 1) % 6;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, done timing.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done: got %b want %b at %0t", done, exp_done, $time);
            end
            exp_done = 1'b0;
            checks++;
            if (busy !== out_valid) begin
                errors++;
                $display("FAIL busy: got %b want %b at %0t", busy, out_valid, $time);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall: got v=%b d=%h l=%b want v=1 d=%h l=%b at %0t",
                             out_valid, out_data, out_last, prev_data, prev_last, $time);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra: got d=%h, want no output at %0t", out_data, $time);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_last !== e.l) begin
                        errors++;
                        $display("FAIL data: got d=%h l=%b want d=%h l=%b at %0t",
                                 out_data, out_last, e.d, e.l, $time);
                    end
                    if (e.l) exp_done = 1'b1;
                end
                pop_count++;
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic load_cells();
        for (int i = 0; i < NE; i++) acc_flat[i*AW +: AW] = AW'(cells[i]);
    endtask

    // Issue a start in the next cycle and queue the expected stream.
    task automatic start_stream(input bit s);
        exp_t e;
        @(posedge clk);
        #1;
        load_cells();
        for (int i = 0; i < NE; i++) begin
            e.d = narrow_ref(cells[i], s);
            e.l = (i == NE - 1);
            q.push_back(e);
        end
        sat_mode = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sat_mode = ~s;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got valid=%b want 1", out_valid);
        end
    endtask

    // Wait for done; optionally check cycles since start were consumed.
    task automatic wait_done(input int exp_cycles);
        int n;
        n = 1;
        while (n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done, want done");
        end else if (exp_cycles >= 0) begin
            checks++;
            if (n != exp_cycles) begin
                errors++;
                $display("FAIL done_cycle: got %0d want %0d", n, exp_cycles);
            end
        end
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (pop_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (pop_count < target) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout: got %0d want %0d", pop_count, target);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending want 0", name, q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sat_mode = 1'b0;
        acc_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_last !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: got v=%b b=%b d=%b l=%b data=%h want all 0",
                     out_valid, busy, done, out_last, out_data);
        end

        // Ordered ramp, full throughput.
        ready_mode = 0;
        for (int i = 0; i < NE; i++) cells[i] = i;
        start_stream(1'b0);
        wait_done(NE + 1);
        check_drained("ramp");

        // Saturation corner values, saturate then truncate back to back.
        ready_mode = 2;
        for (int i = 0; i < NE; i++) cells[i] = $urandom_range(0, 4095);
        cells[0] = 12'h3FF;
        cells[1] = 12'h0FF;
        cells[2] = 12'h100;
        start_stream(1'b1);
        wait_done(-1);
        start_stream(1'b0);
        wait_done(-1);
        check_drained("sat");

        // Fixed backpressure pattern.
        ready_mode = 1;
        for (int i = 0; i < NE; i++) cells[i] = $urandom_range(0, 4095);
        start_stream(1'b1);
        wait_done(-1);
        check_drained("bp");

        // New data and a second start mid-stream must be ignored.
        ready_mode = 0;
        for (int i = 0; i < NE; i++) cells[i] = $urandom_range(0, 4095);
        pop_count = 0;
        start_stream(1'b0);
        wait_pops(10);
        @(posedge clk);
        #1;
        for (int i = 0; i < NE; i++) acc_flat[i*AW +: AW] = 12'hABC;
        sat_mode = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(-1);
        check_drained("restart");
        repeat (3) @(negedge clk);
        check_drained("no_queue");

        // Abort by reset mid-stream.
        ready_mode = 2;
        for (int i = 0; i < NE; i++) cells[i] = $urandom_range(0, 4095);
        pop_count = 0;
        start_stream(1'b1);
        wait_pops(20);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: got v=%b b=%b want 0 0", out_valid, busy);
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < NE; i++) cells[i] = $urandom_range(0, 4095);
        start_stream(1'b0);
        wait_done(-1);
        check_drained("after_abort");

        // All-ones accumulators, start in the cycle right after done.
        ready_mode = 0;
        for (int i = 0; i < NE; i++) cells[i] = 12'hFFF;
        start_stream(1'b1);
        wait_done(NE + 1);
        start_stream(1'b0);
        wait_done(NE + 1);
        check_drained("full");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
